// File: rtl/rx_frame_pkg.sv
// Shared types for the receive frame controller.
package rx_frame_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        PREP = 3'd2,
        SEND = 3'd3,
        DROP = 3'd4
    } rx_frame_state_t;

endpackage

// File: rtl/rx_frame_if.sv
// Outbound frame stream: valid/ready byte stream with last marker plus
// per-frame length and error attributes.
// Handshake: a byte transfers on a clock edge where m_valid && m_ready;
// while m_valid is high and m_ready is low, m_data, m_last, frame_len and
// frame_err hold, and m_valid does not drop until the last byte transfers.
interface rx_frame_if #(
    parameter int MAX_LEN = 64
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic [LEN_W-1:0] frame_len;
    logic             frame_err;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        output frame_len,
        output frame_err,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        input  frame_len,
        input  frame_err,
        output m_ready
    );

endinterface

// File: rtl/rx_frame_buf.sv
// Frame buffer: simple dual-port RAM, synchronous write, registered read.
// Only the read register is reset so the storage maps onto block RAM.
module rx_frame_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: gathers UART bytes into a buffer, closes the
// frame on the rising edge of the line-idle level and replays it downstream.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter  int MAX_LEN = 64,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      rx_data,
    input  logic            rx_done,
    input  logic            rx_par_err,
    input  logic            timeout,
    rx_frame_if.master      m,
    output logic            ovf_err,
    output logic            rx_lost,
    output logic            busy,
    output rx_frame_state_t fsm_state
);

    localparam int              AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    rx_frame_state_t  state;
    logic             to_q;
    logic             to_rise;
    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_ptr;
    logic             err;
    logic             buf_full;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data;

    // to_q resets to 1 so a line that is idle out of reset is not an edge.
    assign to_rise  = timeout & ~to_q;
    assign buf_full = (wr_cnt == MAX_CNT);

    // Buffer control decoded from the current state.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state)
            IDLE: begin
                wr_en   = rx_done;
                wr_addr = '0;
            end
            RECV: begin
                wr_en   = rx_done & ~buf_full;
                wr_addr = AW'(wr_cnt);
            end
            PREP: begin
                rd_en   = 1'b1;
                rd_addr = '0;
            end
            SEND: begin
                // Prefetch the next byte on each non-last transfer: no bubbles.
                rd_en   = m.m_ready & ~m.m_last;
                rd_addr = AW'(rd_ptr + ONE);
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    rx_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign m.m_data  = rd_data;
    assign fsm_state = state;

    // Frame FSM with pointers, timeout edge detect and registered flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            to_q        <= 1'b1;
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            err         <= 1'b0;
            m.m_valid   <= 1'b0;
            m.m_last    <= 1'b0;
            m.frame_len <= '0;
            m.frame_err <= 1'b0;
            ovf_err     <= 1'b0;
            rx_lost     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            to_q    <= timeout;
            ovf_err <= 1'b0;
            rx_lost <= 1'b0;
            case (state)
                IDLE: begin
                    // A stray timeout edge with no data is not a frame.
                    if (rx_done) begin
                        wr_cnt <= ONE;
                        err    <= rx_par_err;
                        state  <= RECV;
                        busy   <= 1'b1;
                    end
                end
                RECV: begin
                    if (rx_done && buf_full) begin
                        // Overflow on the same edge as line idle closes at once.
                        if (to_rise) begin
                            ovf_err <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state <= DROP;
                        end
                    end else begin
                        if (rx_done) begin
                            wr_cnt <= wr_cnt + ONE;
                            err    <= err | rx_par_err;
                        end
                        // A byte arriving with the idle edge belongs to this frame.
                        if (to_rise) begin
                            m.frame_len <= rx_done ? (wr_cnt + ONE) : wr_cnt;
                            m.frame_err <= err | (rx_done & rx_par_err);
                            state       <= PREP;
                        end
                    end
                end
                PREP: begin
                    if (rx_done) begin
                        rx_lost <= 1'b1;
                    end
                    rd_ptr    <= '0;
                    m.m_valid <= 1'b1;
                    m.m_last  <= (m.frame_len == ONE);
                    state     <= SEND;
                end
                SEND: begin
                    if (rx_done) begin
                        rx_lost <= 1'b1;
                    end
                    if (m.m_ready) begin
                        if (m.m_last) begin
                            m.m_valid <= 1'b0;
                            m.m_last  <= 1'b0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            rd_ptr   <= rd_ptr + ONE;
                            m.m_last <= ((rd_ptr + ONE) == (m.frame_len - ONE));
                        end
                    end
                end
                DROP: begin
                    if (to_rise) begin
                        ovf_err <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed frames, expected bytes queued at stimulus
// time, a negedge monitor pops and compares on each stream transfer.
module tb_rx_frame_ctrl;
    import rx_frame_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int EW      = 8 + 1 + LEN_W + 1;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]      rx_data    = 8'h00;
    logic            rx_done    = 1'b0;
    logic            rx_par_err = 1'b0;
    logic            timeout    = 1'b1;
    logic            ovf_err;
    logic            rx_lost;
    logic            busy;
    rx_frame_state_t fsm_state;

    rx_frame_if #(.MAX_LEN(MAX_LEN)) sif ();

    rx_frame_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_par_err (rx_par_err),
        .timeout    (timeout),
        .m          (sif.master),
        .ovf_err    (ovf_err),
        .rx_lost    (rx_lost),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int checks    = 0;
    int errors    = 0;
    int ovf_seen  = 0;
    int lost_seen = 0;
    int exp_ovf   = 0;
    int exp_lost  = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- consumer ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       sif.m_ready = 1'b1;
            1:       sif.m_ready = ~sif.m_ready;
            default: sif.m_ready = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_last  = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !(prev_ready && prev_last)) begin
                check("valid_held", 32'(sif.m_valid), 32'd1);
                if (!prev_ready) check("data_held", 32'(sif.m_data), 32'(prev_data));
            end
            if (sif.m_valid && sif.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no transfer", sif.m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data",      32'(sif.m_data),    32'(mon_e[EW-1 -: 8]));
                    check("last",      32'(sif.m_last),    32'(mon_e[LEN_W+1]));
                    check("frame_len", 32'(sif.frame_len), 32'(mon_e[LEN_W:1]));
                    check("frame_err", 32'(sif.frame_err), 32'(mon_e[0]));
                end
            end
            if (ovf_err) ovf_seen++;
            if (rx_lost) lost_seen++;
            prev_valid = sif.m_valid;
            prev_ready = sif.m_ready;
            prev_last  = sif.m_last;
            prev_data  = sif.m_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pe);
        rx_data    = d;
        rx_done    = 1'b1;
        rx_par_err = pe;
        tick();
        rx_done    = 1'b0;
        rx_par_err = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, expected idle and drained", busy, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    // n bytes, byte i = base + 0x11*i, parity error on byte perr_idx (-1: none).
    task automatic run_frame(input int n, input logic [7:0] base, input int perr_idx);
        logic [7:0] d;
        logic       fe;
        fe = (perr_idx >= 0) && (perr_idx < n);
        timeout = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i * 17);
            send_byte(d, (i == perr_idx));
            if (n <= MAX_LEN) exp_q.push_back({d, (i == n - 1), LEN_W'(n), fe});
        end
        if (n > MAX_LEN) exp_ovf++;
        timeout = 1'b1;
        tick();
        wait_idle();
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (sif.m_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: m_valid=0 after 50 cycles, expected 1", name);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        sif.m_ready = 1'b1;
        repeat (3) tick();

        // Reset state.
        check("rst_m_valid",   32'(sif.m_valid),   32'd0);
        check("rst_m_last",    32'(sif.m_last),    32'd0);
        check("rst_m_data",    32'(sif.m_data),    32'd0);
        check("rst_frame_len", 32'(sif.frame_len), 32'd0);
        check("rst_frame_err", 32'(sif.frame_err), 32'd0);
        check("rst_ovf_err",   32'(ovf_err),       32'd0);
        check("rst_rx_lost",   32'(rx_lost),       32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_state",     32'(fsm_state),     32'(IDLE));

        reset_n = 1'b1;
        repeat (3) tick();
        check("no_false_frame", 32'(busy), 32'd0);

        // 1: basic 3-byte frame 11,22,33.
        run_frame(3, 8'h11, -1);

        // 2: same frame with a toggling consumer.
        ready_mode = 1;
        run_frame(3, 8'h11, -1);
        ready_mode = 0;

        // 3: overflow frame, then a short good frame.
        run_frame(MAX_LEN + 1, 8'hA0, -1);
        run_frame(2, 8'h5A, -1);

        // Full-length frame and single-byte frame boundaries.
        run_frame(MAX_LEN, 8'h01, -1);
        run_frame(1, 8'hC3, -1);

        // 4: parity error on byte 2 of 4, then a clean frame.
        run_frame(4, 8'h40, 1);
        run_frame(3, 8'h50, -1);

        // 5: fifth byte arrives with the idle edge; a byte during replay is lost.
        timeout = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            d = 8'h60 + 8'(i);
            send_byte(d, 1'b0);
            exp_q.push_back({d, 1'b0, LEN_W'(5), 1'b0});
        end
        rx_data = 8'h64;
        rx_done = 1'b1;
        timeout = 1'b1;
        exp_q.push_back({8'h64, 1'b1, LEN_W'(5), 1'b0});
        tick();
        rx_done = 1'b0;
        wait_valid("case5_valid");
        rx_data = 8'hEE;
        rx_done = 1'b1;
        exp_lost++;
        tick();
        rx_done = 1'b0;
        wait_idle();

        // 6: reset while the replay is stalled.
        ready_mode = 2;
        timeout = 1'b0;
        tick();
        send_byte(8'h91, 1'b0);
        send_byte(8'h92, 1'b0);
        send_byte(8'h93, 1'b0);
        timeout = 1'b1;
        tick();
        wait_valid("case6_valid");
        reset_n = 1'b0;
        #1;
        check("rst_mid_m_valid",   32'(sif.m_valid),   32'd0);
        check("rst_mid_busy",      32'(busy),          32'd0);
        check("rst_mid_m_data",    32'(sif.m_data),    32'd0);
        check("rst_mid_frame_len", 32'(sif.frame_len), 32'd0);
        tick();
        tick();
        ready_mode = 0;
        reset_n = 1'b1;
        repeat (6) tick();
        check("post_rst_busy",  32'(busy),      32'd0);
        check("post_rst_state", 32'(fsm_state), 32'(IDLE));
        run_frame(2, 8'h77, -1);

        // Final accounting.
        check("ovf_pulses",  32'(ovf_seen),     32'(exp_ovf));
        check("lost_pulses", 32'(lost_seen),    32'(exp_lost));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
